// File: rtl/thread_sched_pkg.sv
// Shared types and constants for the four-thread barrel issue scheduler.
package thread_sched_pkg;

   localparam int NUM_THREADS = 4;
   localparam int TID_W       = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Each thread starts at the base of its own quarter of instruction memory.
   function automatic int unsigned start_pc(input logic [TID_W-1:0] tid, input int aw);
      return int'(tid) << (aw - 2);
   endfunction

endpackage

// File: rtl/thread_sched_rr_arb4.sv
// Combinational 4-way round-robin pick: first requester after last_i, wrapping.
module rr_arb4 (
   input  logic [3:0] req_i,
   input  logic [1:0] last_i,
   output logic       gnt_valid_o,
   output logic [1:0] gnt_id_o
);

   // Scan from farthest to nearest so the nearest requester after last_i wins.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_id_o    = last_i;
      for (int k = 4; k >= 1; k--) begin
         if (req_i[last_i + 2'(k)]) begin
            gnt_valid_o = 1'b1;
            gnt_id_o    = last_i + 2'(k);
         end
      end
   end

endmodule

// File: rtl/thread_sched.sv
// Fine-grained multithreading issue scheduler: round-robin thread pick, per-thread
// PC tracking, branch redirect with one-cycle flush pulse, halt handling.
module thread_sched
   import thread_sched_pkg::*;
#(
   parameter int INSTMEM_LOG2_DEEP = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         en_i,
   input  logic [NUM_THREADS-1:0]       thread_en_i,
   input  logic                         stall_i,
   input  logic                         redirect_en_i,
   input  logic [TID_W-1:0]             redirect_thread_i,
   input  logic [INSTMEM_LOG2_DEEP-1:0] redirect_pc_i,
   input  logic                         halt_en_i,
   input  logic [TID_W-1:0]             halt_thread_i,
   output logic                         issue_valid_o,
   output logic [INSTMEM_LOG2_DEEP-1:0] pc_o,
   output logic [TID_W-1:0]             thread_id_o,
   output logic                         flush_o,
   output logic [TID_W-1:0]             flush_thread_o,
   output logic [NUM_THREADS-1:0]       thread_active_o,
   output logic                         all_halted_o
);

   localparam int AW = INSTMEM_LOG2_DEEP;

   state_e                 state_q, state_d;
   logic [NUM_THREADS-1:0] active_q, active_d;
   logic [AW-1:0]          pc_q [NUM_THREADS];
   logic [AW-1:0]          pc_d [NUM_THREADS];
   logic [TID_W-1:0]       last_q, last_d;
   logic                   valid_q, valid_d;
   logic [AW-1:0]          pco_q, pco_d;
   logic [TID_W-1:0]       tid_q, tid_d;
   logic                   flush_q, flush_d;
   logic [TID_W-1:0]       flush_tid_q, flush_tid_d;

   logic                   run_act, halt_hit, redir_hit, out_hit;
   logic [NUM_THREADS-1:0] eligible;
   logic                   gnt_valid;
   logic [TID_W-1:0]       gnt_id;

   assign run_act   = (state_q == ST_RUN) && en_i;
   assign halt_hit  = halt_en_i && active_q[halt_thread_i];
   // Halt of the same thread wins over its redirect: no PC update, no flush.
   assign redir_hit = redirect_en_i && active_q[redirect_thread_i] &&
                      !(halt_en_i && (halt_thread_i == redirect_thread_i));
   assign out_hit   = (halt_en_i && (halt_thread_i == tid_q)) ||
                      (redirect_en_i && (redirect_thread_i == tid_q));

   always_comb begin
      eligible = active_q;
      if (redirect_en_i) eligible[redirect_thread_i] = 1'b0;
      if (halt_en_i)     eligible[halt_thread_i]     = 1'b0;
   end

   rr_arb4 u_arb (
      .req_i       (eligible),
      .last_i      (last_q),
      .gnt_valid_o (gnt_valid),
      .gnt_id_o    (gnt_id)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         active_q    <= '0;
         last_q      <= TID_W'(NUM_THREADS - 1);
         valid_q     <= 1'b0;
         pco_q       <= '0;
         tid_q       <= '0;
         flush_q     <= 1'b0;
         flush_tid_q <= '0;
         for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= AW'(start_pc(TID_W'(t), AW));
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         last_q      <= last_d;
         valid_q     <= valid_d;
         pco_q       <= pco_d;
         tid_q       <= tid_d;
         flush_q     <= flush_d;
         flush_tid_q <= flush_tid_d;
         for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= pc_d[t];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en_i) state_d = (thread_en_i == '0) ? ST_DONE : ST_RUN;
         ST_RUN: begin
            if (!en_i)                state_d = ST_IDLE;
            else if (active_d == '0)  state_d = ST_DONE;
         end
         ST_DONE: if (!en_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Issue/flush registers clear whenever the scheduler is not actively running.
   always_comb begin
      active_d    = active_q;
      pc_d        = pc_q;
      last_d      = last_q;
      valid_d     = 1'b0;
      pco_d       = '0;
      tid_d       = '0;
      flush_d     = 1'b0;
      flush_tid_d = '0;
      if ((state_q == ST_IDLE) && en_i) begin
         active_d = thread_en_i;
      end else if (run_act) begin
         if (halt_hit) active_d[halt_thread_i] = 1'b0;
         if (redir_hit) begin
            pc_d[redirect_thread_i] = redirect_pc_i;
            flush_d                 = 1'b1;
            flush_tid_d             = redirect_thread_i;
         end
         if (stall_i) begin
            valid_d = valid_q && !out_hit;
            pco_d   = pco_q;
            tid_d   = tid_q;
         end else if (gnt_valid) begin
            valid_d      = 1'b1;
            tid_d        = gnt_id;
            pco_d        = pc_q[gnt_id];
            pc_d[gnt_id] = pc_q[gnt_id] + AW'(1);
            last_d       = gnt_id;
         end
      end
   end

   always_comb begin
      issue_valid_o   = valid_q;
      pc_o            = pco_q;
      thread_id_o     = tid_q;
      flush_o         = flush_q;
      flush_thread_o  = flush_tid_q;
      thread_active_o = active_q;
      all_halted_o    = (state_q == ST_DONE);
   end

endmodule
